afifo_wpack: RTL and testbench

Write-side packer for the asynchronous FIFO: accepts narrow beats from a valid/ready source in the WClk domain, packs RATIO beats (or fewer on a packet end) into one wide word, and drives the FIFO's write port (we/wfull/d). It is the producer for the FIFO's write end. The read-domain consumer unpacks words using the in-band beat-count and last fields.

---
 rtl/afifo_wpack_pkg.sv | 27 ++
 rtl/afifo_wpack_obuf.sv | 46 ++++
 rtl/afifo_wpack.sv | 110 +++++++++++
 tb/tb_afifo_wpack.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/afifo_wpack_pkg.sv
// afifo_wpack_pkg: shared definitions for the async-FIFO write-side packer
// and its read-side unpacker.
//   calc_fw()  : FIFO word width for a given beat width and packing ratio.
//   NB_LSB     : bit position of the beat-count field (default configuration).
//   LAST_POS   : bit position of the last flag (default configuration).
//   word_t     : {last, nb, data} layout of one FIFO word (default configuration).
package afifo_wpack_pkg;

  // Word = RATIO data lanes + beat count (valid beats - 1) + last flag.
  function automatic int calc_fw(input int iw, input int ratio);
    return iw * ratio + $clog2(ratio) + 1;
  endfunction

  localparam int DEF_IW    = 32;
  localparam int DEF_RATIO = 4;
  localparam int DEF_LR    = $clog2(DEF_RATIO);

  localparam int NB_LSB    = DEF_IW * DEF_RATIO;
  localparam int LAST_POS  = DEF_IW * DEF_RATIO + DEF_LR;

  typedef struct packed {
    logic                        last;
    logic [DEF_LR-1:0]           nb;
    logic [DEF_IW*DEF_RATIO-1:0] data;
  } word_t;

endpackage

// File: rtl/afifo_wpack_obuf.sv
// afifo_wpack_obuf: single-entry output register in front of the FIFO write
// port. Holds one packed word and writes it as soon as the FIFO is not full.
//   WClk, rstn  : write-domain clock, async active-low reset
//   load, din   : load a new word this edge (only legal while free=1)
//   fifo_wfull  : FIFO full flag
//   fifo_we     : FIFO write strobe (never asserted while full)
//   fifo_d      : registered word
//   ovalid      : register holds a word
//   free        : register can accept a word at this edge
module afifo_wpack_obuf #(
  parameter int FW = 131
) (
  input  logic          WClk,
  input  logic          rstn,
  input  logic          load,
  input  logic [FW-1:0] din,
  input  logic          fifo_wfull,
  output logic          fifo_we,
  output logic [FW-1:0] fifo_d,
  output logic          ovalid,
  output logic          free
);

  logic [FW-1:0] obuf;

  assign fifo_we = ovalid & ~fifo_wfull;
  assign fifo_d  = obuf;
  // A word leaving this cycle frees the slot, so a new word can be loaded
  // on the same edge without a bubble.
  assign free    = ~ovalid | fifo_we;

  always_ff @(posedge WClk or negedge rstn) begin
    if (!rstn) begin
      obuf   <= '0;
      ovalid <= 1'b0;
    end else begin
      if (load) begin
        obuf   <= din;
        ovalid <= 1'b1;
      end else if (fifo_we) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/afifo_wpack.sv
// afifo_wpack: write-side packer for the asynchronous FIFO. Packs up to
// RATIO narrow beats into one wide word {last, nb, data} and drives the
// FIFO write port.
//   WClk, rstn           : write-domain clock, async active-low reset
//   s_valid/s_ready      : source handshake; a beat transfers on the edge
//                          where both are high. s_ready depends only on
//                          registered state, never on fifo_wfull.
//   s_data, s_last       : beat payload; s_last closes the word early
//   fifo_we/fifo_wfull/fifo_d : FIFO write port
//   idle                 : nothing held anywhere in the packer
module afifo_wpack
  import afifo_wpack_pkg::*;
#(
  parameter int IW    = 32,
  parameter int RATIO = 4,
  parameter int LR    = $clog2(RATIO),
  parameter int FW    = calc_fw(IW, RATIO)
) (
  input  logic          WClk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [IW-1:0] s_data,
  input  logic          s_last,
  output logic          fifo_we,
  input  logic          fifo_wfull,
  output logic [FW-1:0] fifo_d,
  output logic          idle
);

  localparam int DW = IW * RATIO;

  logic [DW-1:0] acc;
  logic [DW-1:0] merged;
  logic [LR-1:0] cnt;
  logic          pend;
  logic          pend_last;
  logic [LR-1:0] pend_nb;

  logic          accept;
  logic          close;
  logic          obuf_free;
  logic          obuf_load;
  logic [FW-1:0] obuf_din;
  logic          ovalid;

  assign s_ready = ~pend;
  assign accept  = s_valid & s_ready;
  assign close   = accept & ((cnt == LR'(RATIO - 1)) | s_last);

  // Lanes above cnt are already zero because acc is cleared whenever a
  // word leaves it, so merging the current beat yields the final data.
  always_comb begin
    merged = acc;
    merged[int'(cnt) * IW +: IW] = s_data;
  end

  // While pend=1 no beat is accepted, so a pending word and a fresh
  // closing beat never compete for the output register.
  assign obuf_load = obuf_free & (pend | close);
  assign obuf_din  = pend ? {pend_last, pend_nb, acc} : {s_last, cnt, merged};

  always_ff @(posedge WClk or negedge rstn) begin
    if (!rstn) begin
      acc       <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      pend_nb   <= '0;
    end else begin
      if (pend) begin
        if (obuf_free) begin
          acc  <= '0;
          pend <= 1'b0;
        end
      end else if (close) begin
        cnt <= '0;
        if (obuf_free) begin
          acc <= '0;
        end else begin
          // Park the finished word in acc until the output register drains.
          acc       <= merged;
          pend      <= 1'b1;
          pend_last <= s_last;
          pend_nb   <= cnt;
        end
      end else if (accept) begin
        acc <= merged;
        cnt <= cnt + LR'(1);
      end
    end
  end

  afifo_wpack_obuf #(
    .FW(FW)
  ) u_obuf (
    .WClk       (WClk),
    .rstn       (rstn),
    .load       (obuf_load),
    .din        (obuf_din),
    .fifo_wfull (fifo_wfull),
    .fifo_we    (fifo_we),
    .fifo_d     (fifo_d),
    .ovalid     (ovalid),
    .free       (obuf_free)
  );

  assign idle = (cnt == '0) & ~pend & ~ovalid;

endmodule

// File: tb/tb_afifo_wpack.sv
// tb_afifo_wpack: directed bench for afifo_wpack (IW=32, RATIO=4).
module tb_afifo_wpack;
  import afifo_wpack_pkg::*;

  localparam int IW    = 32;
  localparam int RATIO = 4;
  localparam int FW    = calc_fw(IW, RATIO);

  logic          WClk;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_data;
  logic          s_last;
  logic          fifo_we;
  logic          fifo_wfull;
  logic [FW-1:0] fifo_d;
  logic          idle;

  int checks;
  int errors;

  logic [FW-1:0] exp_q[$];

  afifo_wpack #(
    .IW(IW),
    .RATIO(RATIO)
  ) dut (
    .WClk       (WClk),
    .rstn       (rstn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .fifo_we    (fifo_we),
    .fifo_wfull (fifo_wfull),
    .fifo_d     (fifo_d),
    .idle       (idle)
  );

  // Clock / reset
  initial WClk = 1'b0;
  always #5 WClk = ~WClk;

  // Checker
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic last, input logic [1:0] nb,
                                       input logic [127:0] data);
    word_t w;
    w.last = last;
    w.nb   = nb;
    w.data = data;
    return w;
  endfunction

  // Driver: one beat, then settle 1 time unit after the edge.
  task automatic send(input logic [IW-1:0] data, input logic last);
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    @(posedge WClk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge WClk);
    #1;
  endtask

  // Scoreboard: every FIFO write must match the oldest expected word.
  always @(negedge WClk) begin
    if (rstn && fifo_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", fifo_d, '0);
      end else begin
        chk("write_order", fifo_d, exp_q.pop_front());
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rstn       = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    fifo_wfull = 1'b0;

    // Reset state
    repeat (2) @(posedge WClk);
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fifo_we", fifo_we, 0);
    chk("rst_fifo_d", fifo_d, 0);
    chk("rst_idle", idle, 1);
    rstn = 1'b1;
    idle_cycle();

    // Full word, no last
    exp_q.push_back(mk(1'b0, 2'd3, 128'h00000044_00000033_00000022_00000011));
    send(32'h11, 1'b0);
    chk("full_idle_mid", idle, 0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b0);
    chk("full_no_we_early", fifo_we, 0);
    send(32'h44, 1'b0);
    chk("full_we", fifo_we, 1);
    chk("full_d", fifo_d, mk(1'b0, 2'd3, 128'h00000044_00000033_00000022_00000011));
    idle_cycle();
    chk("full_we_drop", fifo_we, 0);
    chk("full_idle_after", idle, 1);

    // Short packet: 2 beats, last on the second
    exp_q.push_back(mk(1'b1, 2'd1, 128'h0000000B_0000000A));
    send(32'hA, 1'b0);
    send(32'hB, 1'b1);
    chk("short_we", fifo_we, 1);
    chk("short_d", fifo_d, mk(1'b1, 2'd1, 128'h0000000B_0000000A));
    idle_cycle();
    chk("short_idle", idle, 1);

    // Sustained stream: 12 beats back-to-back, last on beat 12
    exp_q.push_back(mk(1'b0, 2'd3, 128'h00000104_00000103_00000102_00000101));
    exp_q.push_back(mk(1'b0, 2'd3, 128'h00000108_00000107_00000106_00000105));
    exp_q.push_back(mk(1'b1, 2'd3, 128'h0000010C_0000010B_0000010A_00000109));
    for (int i = 1; i <= 12; i++) begin
      chk("stream_s_ready", s_ready, 1);
      send(32'h100 + 32'(i), i == 12);
      if (i == 4 || i == 8 || i == 12) chk("stream_we_boundary", fifo_we, 1);
      if (i == 5) chk("stream_we_off", fifo_we, 0);
    end
    chk("stream_last_word", fifo_d, mk(1'b1, 2'd3, 128'h0000010C_0000010B_0000010A_00000109));
    idle_cycle();

    // Closing beat on the same edge as a FIFO write: direct reload
    exp_q.push_back(mk(1'b1, 2'd0, 128'h31));
    exp_q.push_back(mk(1'b1, 2'd0, 128'h32));
    send(32'h31, 1'b1);
    chk("simul_d1", fifo_d, mk(1'b1, 2'd0, 128'h31));
    send(32'h32, 1'b1);
    chk("simul_we_held", fifo_we, 1);
    chk("simul_d2", fifo_d, mk(1'b1, 2'd0, 128'h32));
    idle_cycle();
    chk("simul_idle", idle, 1);

    // Backpressure: FIFO full while 8 beats are sent
    fifo_wfull = 1'b1;
    exp_q.push_back(mk(1'b0, 2'd3, 128'h00000204_00000203_00000202_00000201));
    exp_q.push_back(mk(1'b0, 2'd3, 128'h00000208_00000207_00000206_00000205));
    for (int i = 1; i <= 8; i++) begin
      chk("bp_s_ready_before", s_ready, 1);
      send(32'h200 + 32'(i), 1'b0);
    end
    chk("bp_s_ready_low", s_ready, 0);
    chk("bp_no_we", fifo_we, 0);
    chk("bp_obuf_first", fifo_d, mk(1'b0, 2'd3, 128'h00000204_00000203_00000202_00000201));
    idle_cycle();
    chk("bp_still_blocked", s_ready, 0);
    fifo_wfull = 1'b0;
    #1;
    chk("bp_we_first", fifo_we, 1);
    idle_cycle();
    chk("bp_we_second", fifo_we, 1);
    chk("bp_d_second", fifo_d, mk(1'b0, 2'd3, 128'h00000208_00000207_00000206_00000205));
    chk("bp_s_ready_back", s_ready, 1);
    idle_cycle();
    chk("bp_we_done", fifo_we, 0);
    chk("bp_idle", idle, 1);

    // Reset mid-word: held beats are discarded
    send(32'h51, 1'b0);
    send(32'h52, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_we", fifo_we, 0);
    chk("mid_rst_idle", idle, 1);
    idle_cycle();
    rstn = 1'b1;
    idle_cycle();
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_we", fifo_we, 0);
    exp_q.push_back(mk(1'b0, 2'd3, 128'h00000064_00000063_00000062_00000061));
    send(32'h61, 1'b0);
    send(32'h62, 1'b0);
    send(32'h63, 1'b0);
    send(32'h64, 1'b0);
    chk("post_rst_d", fifo_d, mk(1'b0, 2'd3, 128'h00000064_00000063_00000062_00000061));
    idle_cycle();
    idle_cycle();

    chk("all_words_written", 256'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
